// File: rtl/qupls4_rd_rename_alloc_if.sv
// Rename-stage allocation bus: decode-side destination request, commit-side register return,
// and the registered allocation result coming back from the rename block.
interface qupls4_rd_rename_alloc_if #(
    parameter int NPREG = 256,
    parameter int NAREG = 128
);
    localparam int PW = $clog2(NPREG);
    localparam int CW = $clog2(NPREG - NAREG) + 1;

    logic          alloc_valid;
    logic          alloc_ready;
    logic [6:0]    Rd;
    logic          Rdz;
    logic          free_valid;
    logic [PW-1:0] free_preg;
    logic          prd_valid;
    logic [PW-1:0] prd;
    logic [PW-1:0] prd_old;
    logic          prdz;
    logic [CW-1:0] free_count;
    logic          overflow_err;

    modport master (
        output alloc_valid, Rd, Rdz, free_valid, free_preg,
        input  alloc_ready, prd_valid, prd, prd_old, prdz, free_count, overflow_err
    );

    modport slave (
        input  alloc_valid, Rd, Rdz, free_valid, free_preg,
        output alloc_ready, prd_valid, prd, prd_old, prdz, free_count, overflow_err
    );
endinterface

// File: rtl/qupls4_rd_rename_alloc.sv
// Destination-register rename: circular free list of physical registers plus the rename map.
// Define QUPLS4_RENAME_BYPASS_EN to let a register returned while the list is empty feed an allocation directly.
module qupls4_rd_rename_alloc #(
    parameter int NPREG = 256,
    parameter int NAREG = 128
) (
    input  logic clk,
    input  logic rst_n,
    qupls4_rd_rename_alloc_if.slave bus
);
    localparam int DEPTH = NPREG - NAREG;
    localparam int PW    = $clog2(NPREG);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [6:0]    aregno_t;
    typedef logic [PW-1:0] pregno_t;

    pregno_t       rat  [NAREG];
    pregno_t       fifo [DEPTH];
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow_q;

    logic          empty;
    logic          full;
    logic          free_ok;
    logic          byp_avail;
    logic          accept;
    logic          use_byp;
    logic          pop;
    logic          push;
    pregno_t       alloc_pd;
    aregno_t       rd;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd      = bus.Rd;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign free_ok = bus.free_valid && (bus.free_preg != '0);

`ifdef QUPLS4_RENAME_BYPASS_EN
    assign byp_avail = empty && free_ok;
`else
    assign byp_avail = 1'b0;
`endif

    assign bus.alloc_ready = !empty || byp_avail;
    assign accept          = bus.alloc_valid && bus.alloc_ready;

    // A bypassed register never touches the list, so neither pointer moves for it.
    assign use_byp  = accept && !bus.Rdz && byp_avail;
    assign pop      = accept && !bus.Rdz && !empty;
    assign push     = free_ok && !full && !use_byp;
    assign alloc_pd = use_byp ? bus.free_preg : fifo[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NAREG; i++) begin
                rat[i] <= pregno_t'(i);
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= pregno_t'(NAREG + i);
            end
            head          <= '0;
            tail          <= '0;
            count         <= CW'(DEPTH);
            overflow_q    <= 1'b0;
            bus.prd_valid <= 1'b0;
            bus.prd       <= '0;
            bus.prd_old   <= '0;
            bus.prdz      <= 1'b0;
        end else begin
            bus.prd_valid <= accept;

            if (accept) begin
                bus.prdz <= bus.Rdz;
                if (bus.Rdz) begin
                    bus.prd     <= '0;
                    bus.prd_old <= '0;
                end else begin
                    bus.prd     <= alloc_pd;
                    bus.prd_old <= rat[rd];
                    rat[rd]     <= alloc_pd;
                end
            end

            if (pop) begin
                head <= ptr_next(head);
            end

            if (push) begin
                fifo[tail] <= bus.free_preg;
                tail       <= ptr_next(tail);
            end

            // A return into a full list is lost; flag it until the next reset.
            if (free_ok && full) begin
                overflow_q <= 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.free_count   = count;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_qupls4_rd_rename_alloc.sv
// Bench for qupls4_rd_rename_alloc: queue-based free-list/rename-map model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_qupls4_rd_rename_alloc;
    localparam int NPREG = 256;
    localparam int NAREG = 128;
    localparam int DEPTH = NPREG - NAREG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qupls4_rd_rename_alloc_if #(.NPREG(NPREG), .NAREG(NAREG)) bus ();

    qupls4_rd_rename_alloc #(.NPREG(NPREG), .NAREG(NAREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int fl[$];
    int rat_m[NAREG];
    bit ovf_m;
    bit exp_valid;
    int exp_prd;
    int exp_old;
    bit exp_z;
    bit cmp_en = 1'b0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(NAREG + i);
        for (int i = 0; i < NAREG; i++) rat_m[i] = i;
        ovf_m     = 1'b0;
        exp_valid = 1'b0;
        exp_prd   = 0;
        exp_old   = 0;
        exp_z     = 1'b0;
    endtask

    function automatic bit model_ready();
        bit empty;
        bit fok;
        bit byp;
        empty = (fl.size() == 0);
        fok   = bus.free_valid && (bus.free_preg != 0);
        byp   = 1'b0;
`ifdef QUPLS4_RENAME_BYPASS_EN
        byp = empty && fok;
`endif
        return !empty || byp;
    endfunction

    // Applies the cycle's inputs to the model at the clock edge.
    task automatic model_step();
        int  cnt;
        bit  fok;
        bit  acc;
        bit  took;
        int  rd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cnt  = fl.size();
        fok  = bus.free_valid && (bus.free_preg != 0);
        acc  = bus.alloc_valid && model_ready();
        took = 1'b0;
        rd   = int'(bus.Rd);
        exp_valid = acc;
        if (acc) begin
            exp_z = bus.Rdz;
            if (bus.Rdz) begin
                exp_prd = 0;
                exp_old = 0;
            end else begin
                if (cnt == 0) begin
                    exp_prd = int'(bus.free_preg);
                    took    = 1'b1;
                end else begin
                    exp_prd = fl.pop_front();
                end
                exp_old   = rat_m[rd];
                rat_m[rd] = exp_prd;
            end
        end
        if (fok && !took) begin
            if (cnt == DEPTH) ovf_m = 1'b1;
            else              fl.push_back(int'(bus.free_preg));
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (rst_n) chk("alloc_ready", int'(bus.alloc_ready), int'(model_ready()));
            chk("prd_valid", int'(bus.prd_valid), int'(exp_valid));
            chk("prd", int'(bus.prd), exp_prd);
            chk("prd_old", int'(bus.prd_old), exp_old);
            chk("prdz", int'(bus.prdz), int'(exp_z));
            chk("free_count", int'(bus.free_count), fl.size());
            chk("overflow_err", int'(bus.overflow_err), int'(ovf_m));
        end
    end

    task automatic set_in(input bit v, input int rd, input bit rdz, input bit fv, input int fp);
        bus.alloc_valid = v;
        bus.Rd          = 7'(rd);
        bus.Rdz         = rdz;
        bus.free_valid  = fv;
        bus.free_preg   = 8'(fp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic drive(input bit v, input int rd, input bit rdz, input bit fv, input int fp);
        set_in(v, rd, rdz, fv, fp);
        tick();
    endtask

    // Live traffic during the reset cycle must be discarded.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, $urandom_range(0, 127), 1'b0, 1'b1, $urandom_range(1, 255));
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0);
        do_reset();
        chk("rst_count", int'(bus.free_count), 128);
        chk("rst_prd_valid", int'(bus.prd_valid), 0);
        chk("rst_ready", int'(bus.alloc_ready), 1);

        drive(1, 5, 0, 0, 0);
        chk("first_prd", int'(bus.prd), 128);
        chk("first_prd_old", int'(bus.prd_old), 5);
        chk("first_prdz", int'(bus.prdz), 0);
        chk("first_count", int'(bus.free_count), 127);
        drive(1, 5, 0, 0, 0);
        chk("chain_prd", int'(bus.prd), 129);
        chk("chain_prd_old", int'(bus.prd_old), 128);
        drive(0, 0, 0, 0, 0);
        chk("idle_prd_valid", int'(bus.prd_valid), 0);

        do_reset();
        drive(1, 0, 1, 0, 0);
        chk("r0_prd", int'(bus.prd), 0);
        chk("r0_prd_old", int'(bus.prd_old), 0);
        chk("r0_prdz", int'(bus.prdz), 1);
        chk("r0_count", int'(bus.free_count), 128);

        drive(0, 0, 0, 1, 7);
        chk("ovf_set", int'(bus.overflow_err), 1);
        chk("ovf_count", int'(bus.free_count), 128);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk("ovf_sticky", int'(bus.overflow_err), 1);

        do_reset();
        chk("ovf_cleared", int'(bus.overflow_err), 0);
        for (int i = 0; i < DEPTH; i++) drive(1, 10 + (i % 3), 0, 0, 0);
        chk("drain_count", int'(bus.free_count), 0);
        chk("drain_ready", int'(bus.alloc_ready), 0);
        drive(0, 0, 0, 1, 200);
        chk("refill_count", int'(bus.free_count), 1);
        drive(1, 9, 0, 0, 0);
        chk("refill_prd", int'(bus.prd), 200);
        chk("refill_empty", int'(bus.free_count), 0);

        set_in(1, 3, 0, 1, 42);
        #1;
`ifdef QUPLS4_RENAME_BYPASS_EN
        chk("byp_ready", int'(bus.alloc_ready), 1);
        tick();
        chk("byp_prd", int'(bus.prd), 42);
        chk("byp_prd_old", int'(bus.prd_old), 3);
        chk("byp_count", int'(bus.free_count), 0);
`else
        chk("nobyp_ready", int'(bus.alloc_ready), 0);
        tick();
        chk("nobyp_prd_valid", int'(bus.prd_valid), 0);
        chk("nobyp_count", int'(bus.free_count), 1);
`endif

        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int mode;
            int pa;
            int pf;
            int fp;
            mode = (cyc / 300) % 3;
            pa = (mode == 0) ? 90 : (mode == 1) ? 20 : 55;
            pf = (mode == 0) ? 20 : (mode == 1) ? 90 : 55;
            fp = ($urandom_range(0, 99) < 5) ? 0 : $urandom_range(1, 255);
            if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
            drive($urandom_range(0, 99) < pa, $urandom_range(0, 127),
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < pf, fp);
            rst_n = 1'b1;
        end

        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qupls4_rd_rename_alloc.md
QUPLS4_RD_RENAME_ALLOC -- requirements
Module: Qupls4_rd_rename_alloc

Interface
REQ-001 SHALL have parameter NPREG, default 256, meaning physical register count (power of 2, >128).
REQ-002 SHALL have parameter NAREG, default 128, meaning architectural register count; Rd width is 7 bits (aregno_t).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have port alloc_valid, input, 1, decoded destination is presented.
REQ-006 SHALL have port alloc_ready, output, 1, allocation can be accepted this cycle.
REQ-007 SHALL have port Rd, input, 7, decoded architectural destination register.
REQ-008 SHALL have port Rdz, input, 1, destination is r0 (no write).
REQ-009 SHALL have port free_valid, input, 1, commit returns a physical register.
REQ-010 SHALL have port free_preg, input, $clog2(NPREG), physical register being returned.
REQ-011 SHALL have port prd_valid, output, 1, registered allocation result valid.
REQ-012 SHALL have port prd, output, $clog2(NPREG), new physical destination.
REQ-013 SHALL have port prd_old, output, $clog2(NPREG), prior mapping of Rd (freed at commit).
REQ-014 SHALL have port prdz, output, 1, result is the r0 (no-allocation) case.
REQ-015 SHALL have port free_count, output, $clog2(NPREG-NAREG)+1, free-list occupancy.
REQ-016 SHALL have port overflow_err, output, 1, sticky: free attempted into full list.

Function
REQ-017 Free list SHALL be a circular FIFO of NPREG-NAREG entries, head/tail pointers wrapping modulo depth.
REQ-018 A rename map (RAT) SHALL hold NAREG entries of physical register numbers.
REQ-019 Accept SHALL occur when alloc_valid & alloc_ready.
REQ-020 alloc_ready SHALL be (free_count != 0), except as extended in REQ-034.
REQ-021 Accept with Rdz=1 SHALL not pop the FIFO nor alter RAT; next cycle prd=0, prd_old=0, prdz=1.
REQ-022 Accept with Rdz=0 SHALL pop head into prd, output prior RAT[Rd] as prd_old, write RAT[Rd]=prd; prdz=0.
REQ-023 Latency SHALL be 1 cycle: prd_valid asserts the cycle after accept, deasserts the cycle after a non-accept cycle.
REQ-024 Back-to-back accepts to the same Rd SHALL chain: second prd_old equals first prd.
REQ-025 Free with free_valid=1 and free_preg!=0 SHALL push at tail; free_preg==0 SHALL be ignored.
REQ-026 Free when free_count==NPREG-NAREG SHALL be dropped and set overflow_err until reset.
REQ-027 Simultaneous pop and push SHALL leave free_count unchanged, both pointers advancing.
REQ-028 Alloc with Rdz=1 and alloc_valid while free_count==0 SHALL still stall (alloc_ready=0).

Reset
REQ-029 On clk edge with rst_n=0: RAT[i]=i for all i; FIFO entries hold NAREG..NPREG-1 in order; head=0, tail=0, free_count=NPREG-NAREG.
REQ-030 On reset: prd_valid=0, prd=0, prd_old=0, prdz=0, overflow_err=0; alloc_ready reflects reset count next cycle.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight accept or free of that cycle.

Configuration
REQ-032 Macro QUPLS4_RENAME_BYPASS_EN SHALL select same-cycle free-to-alloc bypass.
REQ-033 Without the macro, an empty free list SHALL stall allocation until a freed register is enqueued (one-cycle minimum).
REQ-034 With the macro, when free_count==0 and free_valid & free_preg!=0, alloc_ready=1 and a Rdz=0 accept SHALL take free_preg directly as prd with no FIFO push or pop.

Verification
REQ-035 Reset, then accept Rd=5 Rdz=0 -> next cycle prd=128, prd_old=5, prdz=0, free_count=127.
REQ-036 Accept Rd=5 twice consecutively after reset -> prd=128 then 129; second prd_old=128.
REQ-037 Accept Rdz=1 Rd=0 -> prd=0, prd_old=0, prdz=1, free_count unchanged 128.
REQ-038 Drain 128 allocations -> alloc_ready=0; free 200 -> count 1; next accept prd=200.
REQ-039 free_valid with count=128, free_preg=7 -> overflow_err=1 sticky, count stays 128.
REQ-040 With QUPLS4_RENAME_BYPASS_EN, count=0, free_preg=42 plus accept Rd=3 same cycle -> prd=42, count stays 0; without macro alloc_ready=0 that cycle.
